ternary_seq_ctrl: RTL and testbench

//  Sequencer that exhaustively exercises the 2-input, 1-output ternary datapath in hardware.
//  On start it drives a/b through all 4 combinations, holds each for a settle window, and samples c.
//  It builds a 4-bit truth table and compares it against an expected pattern.

---
 rtl/ternary_seq_ctrl_if.sv | 33 +++
 rtl/ternary_seq_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_ternary_seq_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ternary_seq_ctrl_if.sv
// Control/status bundle between board-level logic and the ternary sweep sequencer.
// Optional error-log fields exist only when TSEQ_ERRLOG_EN is defined.
interface ternary_seq_ctrl_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] tt;
    logic       pass;
`ifdef TSEQ_ERRLOG_EN
    logic [2:0] err_cnt;
    logic [1:0] first_err;
    logic       err_vld;

    modport master (
        output start, abort,
        input  busy, done, tt, pass, err_cnt, first_err, err_vld
    );
    modport slave (
        input  start, abort,
        output busy, done, tt, pass, err_cnt, first_err, err_vld
    );
`else
    modport master (
        output start, abort,
        input  busy, done, tt, pass
    );
    modport slave (
        input  start, abort,
        output busy, done, tt, pass
    );
`endif
endinterface

// File: rtl/ternary_seq_ctrl.sv
// Sweeps a/b of the ternary datapath through all four vectors, captures c into a truth table
// and compares it with EXPECT. Define TSEQ_ERRLOG_EN to add err_cnt/first_err/err_vld.
module ternary_seq_ctrl #(
    parameter int unsigned SETTLE = 1,
    parameter logic [3:0]  EXPECT = 4'b1000
) (
    input  logic              clk,
    input  logic              rst,
    ternary_seq_ctrl_if.slave ctrl,
    input  logic              c_in,
    output logic              a_out,
    output logic              b_out
);

    generate
        if ((SETTLE == 0) || (SETTLE > 255)) begin : g_bad_settle
            $error("ternary_seq_ctrl: SETTLE must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] tt_q, tt_d;
    logic       pass_q, pass_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       a_q, a_d;
    logic       b_q, b_d;

`ifdef TSEQ_ERRLOG_EN
    logic [2:0] err_cnt_q, err_cnt_d;
    logic [1:0] first_err_q, first_err_d;
    logic       err_vld_q, err_vld_d;

    function automatic logic [2:0] count_ones(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
        return n;
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
        return r;
    endfunction
`endif

    // NOTE: every variable gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
        pass_d  = pass_q;
`ifdef TSEQ_ERRLOG_EN
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_vld_d   = err_vld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ctrl.start) begin
                    state_d = S_DRIVE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
                    pass_d  = 1'b0;
`ifdef TSEQ_ERRLOG_EN
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_vld_d   = 1'b0;
`endif
                end
            end
            S_DRIVE: begin
                if (ctrl.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SETTLE_LAST) state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                // Abort wins over the capture: the vector being sampled is discarded.
                if (ctrl.abort) begin
                    state_d = S_IDLE;
                    pass_d  = 1'b0;
                end else begin
                    tt_d[idx_q] = c_in;
                    cnt_d       = '0;
                    if (idx_q == 2'd3) begin
                        // Verdict is taken from the completed table so it is valid with done.
                        state_d = S_DONE;
                        pass_d  = (tt_d == EXPECT);
`ifdef TSEQ_ERRLOG_EN
                        err_cnt_d   = count_ones(tt_d ^ EXPECT);
                        first_err_d = lowest_set(tt_d ^ EXPECT);
                        err_vld_d   = (tt_d != EXPECT);
`endif
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = S_DRIVE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight out of flops.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        a_d    = ((state_d == S_DRIVE) || (state_d == S_SAMPLE)) && idx_d[1];
        b_d    = ((state_d == S_DRIVE) || (state_d == S_SAMPLE)) && idx_d[0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values; the combinational block above uses blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

`ifdef TSEQ_ERRLOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_vld_q   <= 1'b0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_vld_q   <= err_vld_d;
        end
    end

    assign ctrl.err_cnt   = err_cnt_q;
    assign ctrl.first_err = first_err_q;
    assign ctrl.err_vld   = err_vld_q;
`endif

    assign ctrl.busy = busy_q;
    assign ctrl.done = done_q;
    assign ctrl.tt   = tt_q;
    assign ctrl.pass = pass_q;
    assign a_out     = a_q;
    assign b_out     = b_q;

endmodule

// File: tb/tb_ternary_seq_ctrl.sv
// Bench for ternary_seq_ctrl: SETTLE=1 and SETTLE=3 instances driven by directed and random
// sweeps, checked against a cycle-count reference model of the sweep.
module tb_ternary_seq_ctrl;

    localparam logic [3:0] EXP = 4'b1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst1, rst3;
    logic       start_r, abort_r, sel;
    logic [3:0] dp_f;
    logic       a1, b1, a3, b3, c1, c3;
    int         checks, errors;

    ternary_seq_ctrl_if if1 ();
    ternary_seq_ctrl_if if3 ();

    assign if1.start = start_r & ~sel;
    assign if1.abort = abort_r & ~sel;
    assign if3.start = start_r & sel;
    assign if3.abort = abort_r & sel;

    // Ternary datapath stand-in: c is a lookup of the current function table.
    assign c1 = dp_f[{a1, b1}];
    assign c3 = dp_f[{a3, b3}];

    ternary_seq_ctrl #(.SETTLE(1), .EXPECT(EXP)) dut1 (
        .clk(clk), .rst(rst1), .ctrl(if1), .c_in(c1), .a_out(a1), .b_out(b1)
    );
    ternary_seq_ctrl #(.SETTLE(3), .EXPECT(EXP)) dut3 (
        .clk(clk), .rst(rst3), .ctrl(if3), .c_in(c3), .a_out(a3), .b_out(b3)
    );

    logic       o_a, o_b, o_busy, o_done, o_pass;
    logic [3:0] o_tt;
    assign o_a    = sel ? a3 : a1;
    assign o_b    = sel ? b3 : b1;
    assign o_busy = sel ? if3.busy : if1.busy;
    assign o_done = sel ? if3.done : if1.done;
    assign o_pass = sel ? if3.pass : if1.pass;
    assign o_tt   = sel ? if3.tt : if1.tt;
`ifdef TSEQ_ERRLOG_EN
    logic [2:0] o_ec;
    logic [1:0] o_fe;
    logic       o_ev;
    assign o_ec = sel ? if3.err_cnt : if1.err_cnt;
    assign o_fe = sel ? if3.first_err : if1.first_err;
    assign o_ev = sel ? if3.err_vld : if1.err_vld;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: bits of f for every vector whose sample edge already lies before cycle k.
    function automatic logic [3:0] partial_tt(input logic [3:0] f, input int k, input int s);
        logic [3:0] m;
        m = '0;
        for (int v = 0; v < 4; v++) if ((v + 1) * (s + 1) < k) m[v] = 1'b1;
        return f & m;
    endfunction

    function automatic int n_err(input logic [3:0] t);
        logic [3:0] d;
        int n;
        d = t ^ EXP;
        n = 0;
        for (int i = 0; i < 4; i++) if (d[i]) n++;
        return n;
    endfunction

    function automatic int first_err(input logic [3:0] t);
        logic [3:0] d;
        int r;
        d = t ^ EXP;
        r = 0;
        for (int i = 3; i >= 0; i--) if (d[i]) r = i;
        return r;
    endfunction

    task automatic check_errlog(input string tag, input int ec, input int fe);
`ifdef TSEQ_ERRLOG_EN
        check({tag, ".err_cnt"}, 32'(o_ec), 32'(ec));
        check({tag, ".first_err"}, 32'(o_fe), 32'(fe));
        check({tag, ".err_vld"}, 32'(o_ev), 32'(ec != 0));
`endif
    endtask

    task automatic check_idle(input string tag, input logic [3:0] tt, input logic pass);
        check({tag, ".busy"}, 32'(o_busy), 0);
        check({tag, ".done"}, 32'(o_done), 0);
        check({tag, ".ab"}, {30'b0, o_a, o_b}, 0);
        check({tag, ".tt"}, 32'(o_tt), 32'(tt));
        check({tag, ".pass"}, 32'(o_pass), 32'(pass));
    endtask

    // One sweep on the selected instance. abort_k/rst_k: cycle after start at which abort/reset
    // is applied (abort_k=0 means together with start); extra_k: cycle to pulse a stray start.
    task automatic sweep(input logic [3:0] f, input int abort_k, input int rst_k,
                         input int extra_k, input bit start_in_done);
        int s, len;
        logic [3:0] exp_tt;
        s   = sel ? 3 : 1;
        len = 4 * (s + 1);
        dp_f    = f;
        start_r = 1'b1;
        abort_r = (abort_k == 0);
        tick();
        start_r = 1'b0;
        abort_r = 1'b0;
        for (int k = 1; k <= len; k++) begin
            exp_tt = partial_tt(f, k, s);
            check("run.busy", 32'(o_busy), 1);
            check("run.done", 32'(o_done), 0);
            check("run.ab", {30'b0, o_a, o_b}, 32'((k - 1) / (s + 1)));
            check("run.tt", 32'(o_tt), 32'(exp_tt));
            check("run.pass", 32'(o_pass), 0);
            check_errlog("run", 0, 0);
            if (k == abort_k) begin
                abort_r = 1'b1;
                tick();
                abort_r = 1'b0;
                check_idle("abort", exp_tt, 1'b0);
                check_errlog("abort", 0, 0);
                tick();
                check_idle("abort+1", exp_tt, 1'b0);
                return;
            end
            if (k == rst_k) begin
                if (sel) rst3 = 1'b1; else rst1 = 1'b1;
                tick();
                rst1 = 1'b0;
                rst3 = 1'b0;
                check_idle("midrst", 4'b0000, 1'b0);
                check_errlog("midrst", 0, 0);
                return;
            end
            if (k == extra_k) start_r = 1'b1;
            tick();
            start_r = 1'b0;
        end
        check("done.busy", 32'(o_busy), 1);
        check("done.done", 32'(o_done), 1);
        check("done.ab", {30'b0, o_a, o_b}, 0);
        check("done.tt", 32'(o_tt), 32'(f));
        check("done.pass", 32'(o_pass), 32'(f == EXP));
        check_errlog("done", n_err(f), first_err(f));
        if (start_in_done) start_r = 1'b1;
        tick();
        start_r = 1'b0;
        check_idle("post", f, f == EXP);
        check_errlog("post", n_err(f), first_err(f));
    endtask

    initial begin
        int ak, ek;
        logic [3:0] rf;
        checks  = 0;
        errors  = 0;
        sel     = 1'b0;
        start_r = 1'b0;
        abort_r = 1'b0;
        dp_f    = 4'b0000;
        rst1    = 1'b1;
        rst3    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset1", 4'b0000, 1'b0);
        check_errlog("reset1", 0, 0);
        sel = 1'b1;
        check_idle("reset3", 4'b0000, 1'b0);
        sel  = 1'b0;
        rst1 = 1'b0;
        rst3 = 1'b0;

        abort_r = 1'b1;
        tick();
        abort_r = 1'b0;
        check_idle("idle_abort", 4'b0000, 1'b0);

        sweep(4'b1000, -1, -1, -1, 1'b0);
        sweep(4'b1110, -1, -1, 3, 1'b1);
        sweep(4'b1011, 5, -1, -1, 1'b0);
        sweep(4'b0110, 0, -1, -1, 1'b0);
        sweep(4'b1000, -1, -1, -1, 1'b0);

        for (int n = 0; n < 10; n++) begin
            rf = 4'($urandom);
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
            ek = int'($urandom_range(1, 8));
            sweep(rf, ak, -1, ek, 1'($urandom));
        end

        sel = 1'b1;
        sweep(4'b1000, -1, 4, -1, 1'b0);
        sweep(4'b1000, -1, -1, -1, 1'b0);
        sweep(4'b0001, -1, 14, -1, 1'b0);
        for (int n = 0; n < 4; n++) begin
            rf = 4'($urandom);
            ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 16)) : -1;
            sweep(rf, ak, -1, int'($urandom_range(1, 16)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
